// File: rtl/control_pipe.sv
// Pipeline control carrier: latches the decoder control word through ID/EX, EX/MEM and MEM/WB,
// detects load-use hazards, resolves taken branches and kills younger work on branch or external flush.
module control_pipe #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [8:0]       control_i,
    input  logic             valid_i,
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rt_i,
    input  logic [REG_W-1:0] rd_i,
    input  logic             zero_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic [1:0]       ex_alu_op_o,
    output logic             ex_alu_src_o,
    output logic [REG_W-1:0] ex_dest_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             pc_src_o,
    output logic             wb_reg_write_o,
    output logic             wb_mem_to_reg_o,
    output logic [REG_W-1:0] wb_dest_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // control word bit positions
    localparam int B_REG_DST   = 8;
    localparam int B_ALU_SRC   = 7;
    localparam int B_MEM_TO_REG = 6;
    localparam int B_REG_WRITE = 5;
    localparam int B_MEM_READ  = 4;
    localparam int B_MEM_WRITE = 3;
    localparam int B_BRANCH    = 2;

    logic             ex_valid_q, ex_valid_d;
    logic [8:0]       ex_ctrl_q, ex_ctrl_d;
    logic [REG_W-1:0] ex_rt_q, ex_rt_d, ex_rd_q, ex_rd_d;

    logic             mem_valid_q, mem_valid_d;
    logic [4:0]       mem_ctrl_q, mem_ctrl_d;   // {mem_to_reg, reg_write, mem_read, mem_write, branch}
    logic             mem_zero_q, mem_zero_d;
    logic [REG_W-1:0] mem_dest_q, mem_dest_d;

    logic             wb_valid_q, wb_valid_d;
    logic             wb_reg_write_q, wb_reg_write_d;
    logic             wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic [REG_W-1:0] wb_dest_q, wb_dest_d;

    logic             kill;
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_q [2];

    assign stall_o = valid_i & ex_valid_q & ex_ctrl_q[B_MEM_READ] & (ex_rt_q != '0)
                   & ((ex_rt_q == rs_i) | (ex_rt_q == rt_i));
    assign pc_src_o = mem_valid_q & mem_ctrl_q[0] & mem_zero_q;
    assign kill     = pc_src_o | flush_i;

    always_comb begin
        ex_valid_d = valid_i;
        ex_ctrl_d  = control_i;
        ex_rt_d    = rt_i;
        ex_rd_d    = rd_i;
        if (stall_o || kill) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            ex_rt_d    = '0;
            ex_rd_d    = '0;
        end

        mem_valid_d = ex_valid_q & ~kill;
        mem_ctrl_d  = {ex_ctrl_q[B_MEM_TO_REG], ex_ctrl_q[B_REG_WRITE], ex_ctrl_q[B_MEM_READ],
                       ex_ctrl_q[B_MEM_WRITE], ex_ctrl_q[B_BRANCH]};
        mem_zero_d  = zero_i;
        mem_dest_d  = ex_dest_o;

        wb_valid_d      = mem_valid_q;
        wb_reg_write_d  = mem_ctrl_q[3];
        wb_mem_to_reg_d = mem_ctrl_q[4];
        wb_dest_d       = mem_dest_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_valid_q      <= 1'b0;
            ex_ctrl_q       <= '0;
            ex_rt_q         <= '0;
            ex_rd_q         <= '0;
            mem_valid_q     <= 1'b0;
            mem_ctrl_q      <= '0;
            mem_zero_q      <= 1'b0;
            mem_dest_q      <= '0;
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_dest_q       <= '0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_ctrl_q       <= ex_ctrl_d;
            ex_rt_q         <= ex_rt_d;
            ex_rd_q         <= ex_rd_d;
            mem_valid_q     <= mem_valid_d;
            mem_ctrl_q      <= mem_ctrl_d;
            mem_zero_q      <= mem_zero_d;
            mem_dest_q      <= mem_dest_d;
            wb_valid_q      <= wb_valid_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
            wb_dest_q       <= wb_dest_d;
        end
    end

    assign ex_alu_op_o     = ex_ctrl_q[1:0];
    assign ex_alu_src_o    = ex_ctrl_q[B_ALU_SRC];
    assign ex_dest_o       = ex_ctrl_q[B_REG_DST] ? ex_rd_q : ex_rt_q;
    assign mem_read_o      = mem_valid_q & mem_ctrl_q[2];
    assign mem_write_o     = mem_valid_q & mem_ctrl_q[1];
    assign wb_reg_write_o  = wb_valid_q & wb_reg_write_q;
    assign wb_mem_to_reg_o = wb_mem_to_reg_q;
    assign wb_dest_o       = wb_dest_q;

    // saturating performance counters: [0] stall cycles, [1] flush cycles
    assign cnt_inc = {kill, stall_o};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_q[gi] != {CNT_W{1'b1}})) begin
                    cnt_q[gi] <= cnt_q[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign stall_cnt_o = cnt_q[0];
    assign flush_cnt_o = cnt_q[1];

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: per-scenario tasks with hand-computed expectations.
module tb_control_pipe;
    localparam int REG_W = 5;
    localparam int CNT_W = 8;   // narrow counters keep the saturation scenario short

    localparam logic [8:0] C_R   = 9'b100100010;
    localparam logic [8:0] C_LW  = 9'b011110000;
    localparam logic [8:0] C_BEQ = 9'b000000101;
    localparam logic [8:0] C_SW  = 9'b010001000;

    logic             clk = 1'b0;
    logic             rst;
    logic [8:0]       control;
    logic             valid;
    logic [REG_W-1:0] rs, rt, rd;
    logic             zero, flush;
    logic             stall;
    logic [1:0]       ex_alu_op;
    logic             ex_alu_src;
    logic [REG_W-1:0] ex_dest;
    logic             mem_read, mem_write, pc_src, wb_reg_write, wb_mem_to_reg;
    logic [REG_W-1:0] wb_dest;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_pipe #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .control_i(control), .valid_i(valid),
        .rs_i(rs), .rt_i(rt), .rd_i(rd), .zero_i(zero), .flush_i(flush),
        .stall_o(stall), .ex_alu_op_o(ex_alu_op), .ex_alu_src_o(ex_alu_src), .ex_dest_o(ex_dest),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .pc_src_o(pc_src),
        .wb_reg_write_o(wb_reg_write), .wb_mem_to_reg_o(wb_mem_to_reg), .wb_dest_o(wb_dest),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [8:0] c, input int s, input int t, input int d);
        valid   = v;
        control = c;
        rs      = REG_W'(s);
        rt      = REG_W'(t);
        rd      = REG_W'(d);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 9'd0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; zero = 1'b0; flush = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] all_out;
        do_reset();
        all_out = {stall, ex_alu_op, ex_alu_src, ex_dest, mem_read, mem_write, pc_src,
                   wb_reg_write, wb_mem_to_reg, wb_dest, stall_cnt, flush_cnt};
        checks++;
        if (all_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        $display("test_reset: outputs=%h", all_out);
    endtask

    task automatic test_rtype();
        do_reset();
        drive(1'b1, C_R, 1, 2, 3);
        tick();
        idle();
        checks++;
        if (ex_alu_op !== 2'b10 || ex_dest !== 5'd3 || ex_alu_src !== 1'b0) begin
            errors++;
            $display("FAIL rtype_ex: alu_op=%b dest=%0d src=%b expected 10/3/0", ex_alu_op, ex_dest, ex_alu_src);
        end
        tick();
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL rtype_mem: rd=%b wr=%b expected 0/0", mem_read, mem_write);
        end
        tick();
        checks++;
        if (wb_reg_write !== 1'b1 || wb_dest !== 5'd3 || wb_mem_to_reg !== 1'b0) begin
            errors++;
            $display("FAIL rtype_wb: we=%b dest=%0d m2r=%b expected 1/3/0", wb_reg_write, wb_dest, wb_mem_to_reg);
        end
        tick();
        checks++;
        if (wb_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL rtype_wb_once: we=%b expected 0", wb_reg_write);
        end
        $display("test_rtype: wb_dest=%0d", wb_dest);
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, C_LW, 0, 5, 0);
        tick();
        drive(1'b1, C_R, 5, 6, 7);
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL loaduse_stall: got %b expected 1", stall);
        end
        tick();
        checks++;
        if (stall !== 1'b0 || ex_alu_op !== 2'b00 || mem_read !== 1'b1) begin
            errors++;
            $display("FAIL loaduse_bubble: stall=%b ex_alu_op=%b mem_read=%b expected 0/00/1", stall, ex_alu_op, mem_read);
        end
        tick();
        idle();
        checks++;
        if (ex_dest !== 5'd7 || ex_alu_op !== 2'b10 || stall_cnt !== 8'd1) begin
            errors++;
            $display("FAIL loaduse_resume: ex_dest=%0d alu_op=%b stall_cnt=%0d expected 7/10/1", ex_dest, ex_alu_op, stall_cnt);
        end
        checks++;
        if (wb_reg_write !== 1'b1 || wb_mem_to_reg !== 1'b1 || wb_dest !== 5'd5) begin
            errors++;
            $display("FAIL loaduse_lw_wb: we=%b m2r=%b dest=%0d expected 1/1/5", wb_reg_write, wb_mem_to_reg, wb_dest);
        end
        $display("test_load_use: stall_cnt=%0d", stall_cnt);
    endtask

    task automatic run_branch(input logic z, output int wb_writes, output logic pc_seen);
        do_reset();
        wb_writes = 0;
        drive(1'b1, C_BEQ, 1, 2, 0);
        tick();
        zero = z;
        drive(1'b1, C_R, 0, 0, 3);
        tick();
        zero = 1'b0;
        drive(1'b1, C_R, 0, 0, 4);
        pc_seen = pc_src;
        for (int i = 0; i < 5; i++) begin
            tick();
            idle();
            if (wb_reg_write === 1'b1) wb_writes++;
        end
    endtask

    task automatic test_branch_taken();
        int   n;
        logic p;
        run_branch(1'b1, n, p);
        checks++;
        if (p !== 1'b1) begin
            errors++;
            $display("FAIL taken_pc_src: got %b expected 1", p);
        end
        checks++;
        if (n != 0 || flush_cnt !== 8'd1 || pc_src !== 1'b0) begin
            errors++;
            $display("FAIL taken_kill: wb_writes=%0d flush_cnt=%0d pc_src=%b expected 0/1/0", n, flush_cnt, pc_src);
        end
        $display("test_branch_taken: wb_writes=%0d flush_cnt=%0d", n, flush_cnt);
    endtask

    task automatic test_branch_not_taken();
        int   n;
        logic p;
        run_branch(1'b0, n, p);
        checks++;
        if (p !== 1'b0 || n != 2 || flush_cnt !== 8'd0) begin
            errors++;
            $display("FAIL nottaken: pc_src=%b wb_writes=%0d flush_cnt=%0d expected 0/2/0", p, n, flush_cnt);
        end
        $display("test_branch_not_taken: wb_writes=%0d", n);
    endtask

    task automatic test_store_and_r0();
        do_reset();
        drive(1'b1, C_SW, 1, 2, 0);
        tick();
        idle();
        checks++;
        if (mem_write !== 1'b0 || ex_alu_src !== 1'b1) begin
            errors++;
            $display("FAIL sw_ex: mem_write=%b alu_src=%b expected 0/1", mem_write, ex_alu_src);
        end
        tick();
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL sw_mem: mem_write=%b mem_read=%b expected 1/0", mem_write, mem_read);
        end
        tick();
        checks++;
        if (mem_write !== 1'b0 || wb_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL sw_wb: mem_write=%b wb_we=%b expected 0/0", mem_write, wb_reg_write);
        end
        drive(1'b1, C_LW, 0, 0, 0);
        tick();
        drive(1'b1, C_R, 0, 0, 9);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL lw_r0_nostall: got %b expected 0", stall);
        end
        tick();
        idle();
        checks++;
        if (stall_cnt !== 8'd0 || ex_dest !== 5'd9) begin
            errors++;
            $display("FAIL lw_r0_flow: stall_cnt=%0d ex_dest=%0d expected 0/9", stall_cnt, ex_dest);
        end
        $display("test_store_and_r0: stall_cnt=%0d", stall_cnt);
    endtask

    task automatic test_flush_over_stall();
        do_reset();
        drive(1'b1, C_LW, 0, 5, 0);
        tick();
        drive(1'b1, C_R, 5, 0, 6);
        flush = 1'b1;
        #1;
        tick();
        flush = 1'b0;
        idle();
        checks++;
        if (stall_cnt !== 8'd1 || flush_cnt !== 8'd1 || mem_read !== 1'b0 || ex_alu_op !== 2'b00) begin
            errors++;
            $display("FAIL flush_stall: stall_cnt=%0d flush_cnt=%0d mem_read=%b ex_alu_op=%b expected 1/1/0/00",
                     stall_cnt, flush_cnt, mem_read, ex_alu_op);
        end
        $display("test_flush_over_stall: stall_cnt=%0d flush_cnt=%0d", stall_cnt, flush_cnt);
    endtask

    task automatic test_reset_in_flight();
        logic [31:0] all_out;
        do_reset();
        drive(1'b1, C_R, 0, 0, 1);
        tick();
        drive(1'b1, C_LW, 0, 2, 0);
        tick();
        drive(1'b1, C_R, 2, 0, 3);
        tick();
        tick();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        #1;
        all_out = {stall, ex_alu_op, ex_alu_src, ex_dest, mem_read, mem_write, pc_src,
                   wb_reg_write, wb_mem_to_reg, wb_dest, stall_cnt, flush_cnt};
        checks++;
        if (all_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_in_flight: got %h expected 0", all_out);
        end
        $display("test_reset_in_flight: outputs=%h", all_out);
    endtask

    task automatic test_saturation();
        do_reset();
        // back-to-back dependent loads stall every other cycle
        drive(1'b1, C_LW, 5, 5, 0);
        for (int i = 0; i < 600; i++) tick();
        idle();
        checks++;
        if (stall_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL stall_saturate: got %0d expected 255", stall_cnt);
        end
        tick();
        checks++;
        if (stall_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL stall_hold: got %0d expected 255", stall_cnt);
        end
        $display("test_saturation: stall_cnt=%0d", stall_cnt);
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_use();
        test_branch_taken();
        test_branch_not_taken();
        test_store_and_r0();
        test_flush_over_stall();
        test_reset_in_flight();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
